// File: rtl/alu4_bist.sv
// alu4_bist: exhaustive self-test sequencer for the 4-bit alu4 block.
// Define ALU4_BIST_STOP_ON_FAIL_EN to end a run at the first mismatching vector.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// DRIVE | vector applied to alu4, result settling
// CHECK | alu_x compared against the expected value on the exit edge
// DONE  | results held until the next start or reset
module alu4_bist #(
   parameter int NUM_OPS = 14
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  alu_x,
   input  logic [3:0]  alu_y,
   output logic [3:0]  alu_a,
   output logic [3:0]  alu_b,
   output logic [3:0]  alu_opcode,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [11:0] err_count,
   output logic [3:0]  fail_opcode,
   output logic [3:0]  fail_a,
   output logic [3:0]  fail_b
);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

   localparam logic [3:0] OP_LAST = 4'(NUM_OPS - 1);

   state_t     state, state_next;
   logic       load_first, load_next;
   logic       mismatch, last_vec;
   logic [3:0] x_exp;
   logic       unused_y;

   // alu_y is not part of the check
   assign unused_y = ^alu_y;

   function automatic logic [3:0] expect_x(input logic [3:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
      logic [3:0] r;
      r = 4'h0;
      case (op)
         4'd0:    r = {3'b000, |a};
         4'd1:    r = {3'b000, ^a};
         4'd2:    r = {3'b000, &a};
         4'd3:    r = {3'b000, ~|a};
         4'd4:    r = ~a;
         4'd5:    r = {3'b000, ~|b};
         4'd6:    r = ~b;
         4'd7:    r = {3'b000, &b};
         4'd8:    r = a & b;
         4'd9:    r = a | b;
         4'd10:   r = a ^ b;
         4'd11:   r = {3'b000, a > b};
         4'd12:   r = {3'b000, a < b};
         4'd13:   r = {3'b000, a == b};
         default: r = 4'h0;
      endcase
      return r;
   endfunction

   always_comb begin
      state_next = state;
      load_first = 1'b0;
      load_next  = 1'b0;
      x_exp      = expect_x(alu_opcode, alu_a, alu_b);
      mismatch   = (state == CHECK) && (alu_x != x_exp);
      last_vec   = (alu_opcode == OP_LAST) && (alu_a == 4'hf) && (alu_b == 4'hf);
      case (state)
         IDLE: begin
            if (start) begin
               state_next = DRIVE;
               load_first = 1'b1;
            end
         end
         DRIVE: state_next = CHECK;
         CHECK: begin
`ifdef ALU4_BIST_STOP_ON_FAIL_EN
            if (mismatch || last_vec) begin
               state_next = DONE;
            end else begin
               state_next = DRIVE;
               load_next  = 1'b1;
            end
`else
            if (last_vec) begin
               state_next = DONE;
            end else begin
               state_next = DRIVE;
               load_next  = 1'b1;
            end
`endif
         end
         DONE: begin
            if (start) begin
               state_next = DRIVE;
               load_first = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state == DRIVE) || (state == CHECK);
   assign done = (state == DONE);
   assign pass = (state == DONE) && (err_count == 12'd0);

   // {alu_opcode, alu_a, alu_b} doubles as the vector index, b fastest
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         alu_a       <= 4'h0;
         alu_b       <= 4'h0;
         alu_opcode  <= 4'h0;
         err_count   <= 12'd0;
         fail_opcode <= 4'h0;
         fail_a      <= 4'h0;
         fail_b      <= 4'h0;
      end else begin
         state <= state_next;
         if (load_first) begin
            {alu_opcode, alu_a, alu_b} <= 12'd0;
            err_count   <= 12'd0;
            fail_opcode <= 4'h0;
            fail_a      <= 4'h0;
            fail_b      <= 4'h0;
         end else if (load_next) begin
            {alu_opcode, alu_a, alu_b} <= {alu_opcode, alu_a, alu_b} + 12'd1;
         end
         if (mismatch) begin
            err_count <= err_count + 12'd1;
            if (err_count == 12'd0) begin
               fail_opcode <= alu_opcode;
               fail_a      <= alu_a;
               fail_b      <= alu_b;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu4_bist.sv
// tb_alu4_bist: randomized self-checking bench for alu4_bist against a behavioural alu4
// model; expectations follow ALU4_BIST_STOP_ON_FAIL_EN when it is defined.
module tb_alu4_bist;

   localparam int N  = 14;
   localparam int NV = N * 256;
`ifdef ALU4_BIST_STOP_ON_FAIL_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, start1;
   logic [3:0]  alu_x, alu_y, alu_a, alu_b, alu_opcode, fail_opcode, fail_a, fail_b;
   logic        busy, done, pass;
   logic [11:0] err_count;
   logic [3:0]  alu_x1, alu_y1, alu_a1, alu_b1, alu_opcode1, fail_opcode1, fail_a1, fail_b1;
   logic        busy1, done1, pass1;
   logic [11:0] err_count1;

   bit fault_op13 = 1'b0;
   int fault_idx  = -1;
   int n_checks   = 0;
   int n_fail     = 0;

   alu4_bist #(.NUM_OPS(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .alu_x(alu_x), .alu_y(alu_y),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .busy(busy), .done(done),
      .pass(pass), .err_count(err_count), .fail_opcode(fail_opcode), .fail_a(fail_a),
      .fail_b(fail_b)
   );

   alu4_bist #(.NUM_OPS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .alu_x(alu_x1), .alu_y(alu_y1),
      .alu_a(alu_a1), .alu_b(alu_b1), .alu_opcode(alu_opcode1), .busy(busy1), .done(done1),
      .pass(pass1), .err_count(err_count1), .fail_opcode(fail_opcode1), .fail_a(fail_a1),
      .fail_b(fail_b1)
   );

   // behavioural alu4, computed with integer arithmetic
   function automatic logic [3:0] ref_x(input int op, input int a, input int b);
      int r;
      r = 0;
      case (op)
         0:  r = (a != 0) ? 1 : 0;
         1:  for (int i = 0; i < 4; i++) r = r ^ ((a >> i) & 1);
         2:  r = (a == 15) ? 1 : 0;
         3:  r = (a == 0) ? 1 : 0;
         4:  r = 15 - a;
         5:  r = (b == 0) ? 1 : 0;
         6:  r = 15 - b;
         7:  r = (b == 15) ? 1 : 0;
         8:  r = a & b;
         9:  r = a | b;
         10: r = a ^ b;
         11: r = (a > b) ? 1 : 0;
         12: r = (a < b) ? 1 : 0;
         13: r = (a == b) ? 1 : 0;
         default: r = 0;
      endcase
      return 4'(r);
   endfunction

   always_comb begin
      alu_x = ref_x(int'(alu_opcode), int'(alu_a), int'(alu_b));
      if (fault_op13 && alu_opcode == 4'd13) alu_x = alu_x ^ 4'h1;
      if (fault_idx == int'({alu_opcode, alu_a, alu_b})) alu_x = alu_x ^ 4'h1;
   end
   assign alu_y  = ~alu_x;
   assign alu_x1 = ref_x(int'(alu_opcode1), int'(alu_a1), int'(alu_b1));
   assign alu_y1 = 4'h0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_a"}, alu_a, 0);
      check({tag, "_b"}, alu_b, 0);
      check({tag, "_op"}, alu_opcode, 0);
      check({tag, "_err"}, err_count, 0);
      check({tag, "_fop"}, fail_opcode, 0);
      check({tag, "_fa"}, fail_a, 0);
      check({tag, "_fb"}, fail_b, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_pass"}, pass, 0);
   endtask

   // Pulses (or holds) start, then follows the run to done checking the vector walk.
   task automatic run(input bit hold, input int budget, output int cycles);
      int seq_bad  = 0;
      int busy_bad = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start  = hold;
      cycles = 0;
      while (!done && cycles < budget) begin
         if ({alu_opcode, alu_a, alu_b} != 12'(cycles / 2)) seq_bad++;
         if (!busy) busy_bad++;
         if (!hold) start = ($urandom_range(0, 31) == 0);
         @(posedge clk); #1;
         cycles++;
      end
      start = hold;
      check("seq_walk", seq_bad, 0);
      check("busy_run", busy_bad, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int fv;
      int ev;
      rst_n  = 1'b0;
      start  = 1'b1;
      start1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset_checks("rst");
      check("rst_busy1", busy1, 0);
      start  = 1'b0;
      start1 = 1'b0;
      rst_n  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_busy", busy, 0);

      // golden run
      run(1'b0, 2 * NV + 10, cyc);
      check("gold_cycles", cyc, 2 * NV);
      check("gold_done", done, 1);
      check("gold_pass", pass, 1);
      check("gold_err", err_count, 0);
      repeat (5) @(posedge clk);
      #1;
      check("gold_hold_done", done, 1);
      check("gold_hold_pass", pass, 1);

      // opcode 13 inverted
      fault_op13 = 1'b1;
      fv = 13 * 256;
      run(1'b0, 2 * NV + 10, cyc);
      ev = STOP ? fv : NV - 1;
      check("op13_cycles", cyc, STOP ? 2 * fv + 2 : 2 * NV);
      check("op13_done", done, 1);
      check("op13_pass", pass, 0);
      check("op13_err", err_count, STOP ? 1 : 256);
      check("op13_fop", fail_opcode, 13);
      check("op13_fa", fail_a, 0);
      check("op13_fb", fail_b, 0);
      check("op13_vec", {alu_opcode, alu_a, alu_b}, ev);
      fault_op13 = 1'b0;

      // single random faulty vector
      for (int i = 0; i < 3; i++) begin
         fv = $urandom_range(0, NV - 1);
         fault_idx = fv;
         run(1'b0, 2 * NV + 10, cyc);
         check("rnd_cycles", cyc, STOP ? 2 * fv + 2 : 2 * NV);
         check("rnd_err", err_count, 1);
         check("rnd_pass", pass, 0);
         check("rnd_fop", fail_opcode, fv / 256);
         check("rnd_fa", fail_a, (fv / 16) % 16);
         check("rnd_fb", fail_b, fv % 16);
         fault_idx = -1;
      end

      // reset at cycle 1000 of a run that has already seen a mismatch
      fault_idx = $urandom_range(0, 400);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (999) @(posedge clk);
      #1;
      check("mid_err_pre", err_count, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      fault_idx = -1;
      reset_checks("mid");
      repeat (20) @(posedge clk);
      #1;
      check("mid_idle_done", done, 0);
      check("mid_idle_busy", busy, 0);
      run(1'b0, 2 * NV + 10, cyc);
      check("mid_rerun_cycles", cyc, 2 * NV);
      check("mid_rerun_pass", pass, 1);

      // start held high through a faulty run, then restart from DONE
      fault_op13 = 1'b1;
      run(1'b1, 2 * NV + 10, cyc);
      check("hold_cycles", cyc, STOP ? 2 * 13 * 256 + 2 : 2 * NV);
      check("hold_err", err_count, STOP ? 1 : 256);
      @(posedge clk); #1;
      start = 1'b0;
      fault_op13 = 1'b0;
      check("hold_restart_busy", busy, 1);
      check("hold_restart_done", done, 0);
      check("hold_restart_err", err_count, 0);
      check("hold_restart_fop", fail_opcode, 0);
      check("hold_restart_vec", {alu_opcode, alu_a, alu_b}, 0);
      cyc = 0;
      while (!done && cyc < 2 * NV + 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("hold_rerun_cycles", cyc, 2 * NV);
      check("hold_rerun_pass", pass, 1);

      // single-opcode instance
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      cyc = 0;
      while (!done1 && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("one_op_cycles", cyc, 512);
      check("one_op_pass", pass1, 1);
      check("one_op_err", err_count1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu4_bist.md
ALU4_BIST -- requirements
Module: alu4_bist

Interface
REQ-001 The block SHALL have the parameter NUM_OPS, default 14, meaning the number of opcodes exercised, starting at 0 (legal range 1..14).
REQ-002 The block SHALL have the port clk, input, 1, the sole clock (rising edge).
REQ-003 The block SHALL have the port rst_n, input, 1, the synchronous active-low reset.
REQ-004 The block SHALL have the port start, input, 1, which requests a self-test run.
REQ-005 The block SHALL have the port alu_x, input, 4, the x result returned by alu4.
REQ-006 The block SHALL have the port alu_y, input, 4, the y result of alu4, which is unchecked and ignored.
REQ-007 The block SHALL have the port alu_a, output, 4, the operand a driven to alu4.
REQ-008 The block SHALL have the port alu_b, output, 4, the operand b driven to alu4.
REQ-009 The block SHALL have the port alu_opcode, output, 4, the opcode driven to alu4.
REQ-010 The block SHALL have the ports busy, done and pass, each output, 1, meaning respectively run in progress, run complete, and zero mismatches.
REQ-011 The block SHALL have the port err_count, output, 12, the mismatch count.
REQ-012 The block SHALL have the ports fail_opcode, fail_a and fail_b, each output, 4, holding the first failing vector.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, DRIVE, CHECK and DONE.
REQ-014 The FSM SHALL make these transitions: IDLE->DRIVE when start=1; DRIVE->CHECK always; CHECK->DRIVE if vectors remain, else ->DONE; DONE->DRIVE when start=1 (restart from vector 0, clearing results), else stays in DONE.
REQ-015 The vector index SHALL be {opcode,a,b}, with b fastest and opcode slowest; opcodes run 0..NUM_OPS-1, and a and b each run 0..15, giving NUM_OPS*256 vectors.
REQ-016 alu_a, alu_b and alu_opcode SHALL be registered and SHALL change only on entry to DRIVE; they SHALL hold their values through CHECK.
REQ-017 The block SHALL compare alu_x with the expected value on the clock edge that leaves CHECK; a mismatch SHALL increment err_count and, on the first mismatch only, SHALL capture fail_opcode, fail_a and fail_b.
REQ-018 The expected x for opcodes 0..7 SHALL be: 0 = |a, 1 = ^a, 2 = &a, 3 = !a, 4 = ~a, 5 = !b, 6 = ~b, 7 = &b.
REQ-019 The expected x for opcodes 8..13 SHALL be: 8 = a&b, 9 = a|b, 10 = a^b, 11 = a>b, 12 = a<b, 13 = a==b; all comparisons are unsigned.
REQ-020 Every 1-bit expected result SHALL be zero-extended to 4 bits (000r).
REQ-021 Each vector SHALL take exactly 2 cycles; done SHALL assert exactly 2*NUM_OPS*256 cycles after the edge that samples start (7168 cycles for the default).
REQ-022 busy SHALL be 1 in DRIVE and CHECK and 0 otherwise; done SHALL be 1 only in DONE; pass SHALL be 1 only in DONE with err_count=0.
REQ-023 A start pulse SHALL be ignored while busy=1.
REQ-024 err_count SHALL NOT wrap, because 3584 is less than 4096.
REQ-025 Results SHALL hold in DONE until the next start or reset.

Reset
REQ-026 While rst_n=0 at a clk edge, the state SHALL go to IDLE and every output SHALL go to 0: alu_a, alu_b, alu_opcode, err_count, fail_opcode, fail_a, fail_b, busy, done and pass.
REQ-027 Reset SHALL take precedence over start.
REQ-028 A reset asserted mid-run SHALL abort the run without asserting done; the next run SHALL restart at vector 0.

Configuration
REQ-029 The macro ALU4_BIST_STOP_ON_FAIL_EN SHALL control stop-on-fail behaviour.
REQ-030 When ALU4_BIST_STOP_ON_FAIL_EN is defined, the first mismatch SHALL send CHECK->DONE: err_count becomes 1, alu_a, alu_b and alu_opcode keep the failing vector, and pass=0.
REQ-031 When ALU4_BIST_STOP_ON_FAIL_EN is undefined, the block SHALL always run all vectors and count every mismatch.

Verification
REQ-032 The bench SHALL cover: golden alu4, 1-cycle start pulse -> busy for 7168 cycles, then done=1, pass=1, err_count=0.
REQ-033 The bench SHALL cover: an alu4 model with opcode 13 result inverted, macro off -> done=1, pass=0, err_count=256, fail_opcode=13, fail_a=0, fail_b=0.
REQ-034 The bench SHALL cover: the same faulty model, macro on -> done after 2*13*256+2 = 6658 cycles, err_count=1, alu_opcode=13, alu_a=0, alu_b=0.
REQ-035 The bench SHALL cover: rst_n=0 for 1 cycle at cycle 1000 of a run -> all outputs 0, state IDLE; a subsequent start -> full 7168-cycle pass.
REQ-036 The bench SHALL cover: start held high throughout a run -> no restart mid-run; after DONE is entered, DONE->DRIVE on the next start sample with results cleared.
REQ-037 The bench SHALL cover: NUM_OPS=1 with golden alu4 -> done after 512 cycles, pass=1.
